// File: rtl/ser_rcvr_mc.sv
// rtl/ser_rcvr_mc.sv - multi-lane framed serial receiver with parity and FWFT output FIFO
module ser_rcvr_mc #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_bit_en,
    input  logic                      i_fs,
    input  logic [LANES-1:0]          i_d,
    output logic [LANES*DATA_W-1:0]   o_data,
    output logic [LANES-1:0]          o_par_err,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic                      o_frm_err,
    output logic                      o_ovf,
    output logic [15:0]               o_ovf_cnt
);

    localparam int FRAME_LEN = DATA_W + PARITY;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int EW        = LANES * (DATA_W + 1);

    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

    logic [0:0]              state;
    logic [CW-1:0]           cnt;
    logic [FRAME_LEN-2:0]    sh   [LANES];
    logic [FRAME_LEN-1:0]    word [LANES];
    logic [LANES*DATA_W-1:0] push_data;
    logic [LANES-1:0]        push_perr;
    logic                    frm_hit;
    logic                    push;

    // word[k] is the lane's frame including the bit being sampled right now
    always_comb begin
        push_data = '0;
        push_perr = '0;
        for (int k = 0; k < LANES; k++) begin
            word[k] = {sh[k], i_d[k]};
            push_data[k*DATA_W +: DATA_W] = word[k][FRAME_LEN-1 -: DATA_W];
            push_perr[k] = (PARITY != 0) && (^word[k]);
        end
    end

    assign frm_hit = i_bit_en && i_fs && (state == SHIFT);
    assign push    = i_bit_en && !i_fs && (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            o_frm_err <= 1'b0;
        end else begin
            o_frm_err <= frm_hit;
            if (i_bit_en) begin
                if (i_fs) begin
                    state <= SHIFT;
                    cnt   <= CW'(1);
                end else if (state == SHIFT) begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Partial words are discarded by the counter, so the shifters need no reset
    always_ff @(posedge clk) begin
        if (i_bit_en && (i_fs || state == SHIFT)) begin
            for (int k = 0; k < LANES; k++)
                sh[k] <= word[k][FRAME_LEN-2:0];
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          wr;
    logic          drop;

    assign full = (count == DEPTH);
    assign pop  = o_vld && i_rdy;
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {push_perr, push_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_ovf     <= 1'b0;
            o_ovf_cnt <= '0;
        end else begin
            o_ovf <= drop;
            if (drop && o_ovf_cnt != 16'hFFFF)
                o_ovf_cnt <= o_ovf_cnt + 1'b1;
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is masked while empty so stale RAM never leaks out
    assign o_vld     = (count != '0);
    assign head      = mem[rd_ptr];
    assign o_data    = o_vld ? head[LANES*DATA_W-1:0] : '0;
    assign o_par_err = o_vld ? head[EW-1 -: LANES] : '0;

endmodule

// File: tb/tb_ser_rcvr_mc.sv
// tb/tb_ser_rcvr_mc.sv - directed-vector bench for ser_rcvr_mc
module tb_ser_rcvr_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_en;
    logic        fs_a, d_a, rdy_a;
    logic        fs_b, rdy_b;
    logic [1:0]  d_b;

    logic [15:0] o_data_a;
    logic        o_par_err_a, o_vld_a, o_frm_err_a, o_ovf_a;
    logic [15:0] o_ovf_cnt_a;
    logic [31:0] o_data_b;
    logic [1:0]  o_par_err_b;
    logic        o_vld_b, o_frm_err_b, o_ovf_b;
    logic [15:0] o_ovf_cnt_b;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int frm_n = 0;
    int ovf_n = 0;
    logic [15:0] rx [$];
    int          pop_cyc [$];

    always #5 clk = ~clk;

    ser_rcvr_mc #(.DATA_W(16), .LANES(1), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit_en  (bit_en),
        .i_fs      (fs_a),
        .i_d       (d_a),
        .o_data    (o_data_a),
        .o_par_err (o_par_err_a),
        .o_vld     (o_vld_a),
        .i_rdy     (rdy_a),
        .o_frm_err (o_frm_err_a),
        .o_ovf     (o_ovf_a),
        .o_ovf_cnt (o_ovf_cnt_a)
    );

    ser_rcvr_mc #(.DATA_W(16), .LANES(2), .PARITY(1), .FIFO_DEPTH(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit_en  (bit_en),
        .i_fs      (fs_b),
        .i_d       (d_b),
        .o_data    (o_data_b),
        .o_par_err (o_par_err_b),
        .o_vld     (o_vld_b),
        .i_rdy     (rdy_b),
        .o_frm_err (o_frm_err_b),
        .o_ovf     (o_ovf_b),
        .o_ovf_cnt (o_ovf_cnt_b)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && o_vld_a && rdy_a) begin
            rx.push_back(o_data_a);
            pop_cyc.push_back(cyc);
        end
        if (o_frm_err_a) frm_n <= frm_n + 1;
        if (o_ovf_a)     ovf_n <= ovf_n + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fs_a   = 1'b0;
        fs_b   = 1'b0;
        bit_en = 1'b1;
        repeat (n) step();
    endtask

    task automatic bit_a(input logic fs, input logic d);
        fs_a   = fs;
        d_a    = d;
        bit_en = 1'b1;
        step();
    endtask

    task automatic tx_a(input logic [15:0] w, input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bit_a(i == 0, w[15-i]);
            if (gap > 0) begin
                bit_en = 1'b0;
                repeat (gap) step();
            end
        end
        fs_a = 1'b0;
    endtask

    task automatic tx_b(input logic [16:0] f1, input logic [16:0] f0);
        for (int i = 0; i < 17; i++) begin
            fs_b   = (i == 0);
            d_b    = {f1[16-i], f0[16-i]};
            bit_en = 1'b1;
            step();
        end
        fs_b = 1'b0;
    endtask

    initial begin
        int base;
        int frm0;
        int ovf0;

        rst_n = 1'b0; bit_en = 1'b1;
        fs_a = 1'b0; d_a = 1'b0; rdy_a = 1'b0;
        fs_b = 1'b0; d_b = 2'b00; rdy_b = 1'b0;
        repeat (2) step();
        chk("rst_vld_a",  o_vld_a, 0);
        chk("rst_data_a", o_data_a, 0);
        chk("rst_ovfc_a", o_ovf_cnt_a, 0);
        chk("rst_frm_a",  o_frm_err_a, 0);
        chk("rst_vld_b",  o_vld_b, 0);
        chk("rst_data_b", o_data_b, 0);
        chk("rst_perr_b", o_par_err_b, 0);
        rst_n = 1'b1;
        idle(2);

        // back-to-back counting words
        rdy_a = 1'b1;
        base = rx.size(); frm0 = frm_n; ovf0 = ovf_n;
        for (int w = 0; w < 6; w++) tx_a(16'(w), 0, 16);
        idle(3);
        chk("cnt_n", rx.size() - base, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("cnt_w%0d", i), rx[base+i], i);
        for (int i = 1; i < 6; i++) chk($sformatf("cnt_gap%0d", i), pop_cyc[base+i] - pop_cyc[base+i-1], 16);
        chk("cnt_frm", frm_n - frm0, 0);
        chk("cnt_ovf", ovf_n - ovf0, 0);

        // two lanes with parity
        rdy_b = 1'b0;
        tx_b({16'h0001, 1'b0}, {16'hA5A5, 1'b0});
        chk("par_vld",  o_vld_b, 1);
        chk("par_data", o_data_b, 32'h0001_A5A5);
        chk("par_err",  o_par_err_b, 2'b10);
        tx_b({16'h0007, 1'b1}, {16'h0003, 1'b0});
        chk("par_hold", o_data_b, 32'h0001_A5A5);
        chk("par_hold_e", o_par_err_b, 2'b10);
        rdy_b = 1'b1; step(); rdy_b = 1'b0;
        chk("par_data2", o_data_b, 32'h0007_0003);
        chk("par_err2",  o_par_err_b, 2'b00);
        rdy_b = 1'b1; step(); rdy_b = 1'b0;
        chk("par_empty", o_vld_b, 0);

        // one strobe in four
        rdy_a = 1'b0;
        idle(2);
        tx_a(16'h1234, 3, 15);
        chk("ben_early", o_vld_a, 0);
        bit_a(1'b0, 1'b0);
        chk("ben_vld",  o_vld_a, 1);
        chk("ben_data", o_data_a, 16'h1234);
        bit_en = 1'b0;
        repeat (3) step();
        chk("ben_hold", o_data_a, 16'h1234);
        rdy_a = 1'b1; step();
        chk("ben_pop", o_vld_a, 0);

        // framing error at bit 7
        base = rx.size(); frm0 = frm_n;
        idle(2);
        tx_a(16'hDEAD, 0, 7);
        tx_a(16'hBEEF, 0, 16);
        idle(3);
        chk("frm_pulses", frm_n - frm0, 1);
        chk("frm_n", rx.size() - base, 1);
        chk("frm_word", rx[base], 16'hBEEF);

        // overflow, then push with simultaneous pop when full
        rdy_a = 1'b0;
        base = rx.size(); ovf0 = ovf_n;
        for (int w = 1; w <= 6; w++) tx_a(16'(w), 0, 16);
        idle(2);
        chk("ovf_pulses", ovf_n - ovf0, 2);
        chk("ovf_cnt",    o_ovf_cnt_a, 2);
        chk("ovf_head",   o_data_a, 1);
        chk("ovf_perr",   o_par_err_a, 0);
        tx_a(16'h0007, 0, 15);
        rdy_a = 1'b1;
        bit_a(1'b0, 1'b1);
        idle(8);
        chk("ovf_n", rx.size() - base, 5);
        chk("ovf_w0", rx[base+0], 1);
        chk("ovf_w1", rx[base+1], 2);
        chk("ovf_w2", rx[base+2], 3);
        chk("ovf_w3", rx[base+3], 4);
        chk("ovf_w4", rx[base+4], 7);
        chk("ovf_cnt2", o_ovf_cnt_a, 2);

        // reset in the middle of a frame with a word pending
        rdy_a = 1'b0;
        tx_a(16'h0F0F, 0, 16);
        chk("mrst_pre", o_vld_a, 1);
        tx_a(16'h5555, 0, 9);
        rst_n = 1'b0;
        #2;
        chk("mrst_vld",  o_vld_a, 0);
        chk("mrst_data", o_data_a, 0);
        chk("mrst_ovfc", o_ovf_cnt_a, 0);
        chk("mrst_frm",  o_frm_err_a, 0);
        chk("mrst_ovf",  o_ovf_a, 0);
        repeat (2) step();
        rst_n = 1'b1;
        base = rx.size();
        rdy_a = 1'b1;
        idle(2);
        tx_a(16'h00FF, 0, 16);
        idle(3);
        chk("mrst_n",    rx.size() - base, 1);
        chk("mrst_word", rx[base], 16'h00FF);
        chk("mrst_ovfc2", o_ovf_cnt_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
